bus_memory: RTL
===============

# bus_memory

Memory responder at the far end of the CPU's instruction and data buses. Serves single-cycle combinational reads to the fetch stage and the data-memory stage, and takes synchronous writes from the data bus. A byte-stream boot loader fills instruction memory after reset while the CPU is held in reset. The block then releases the CPU and enters normal operation.

## Interface
- IMEM_WORDS, 256: instruction memory depth in 32-bit words (power of 2).
- DMEM_WORDS, 256: data memory depth in 32-bit words (power of 2).
- Clocking and reset (already decided): reset i_reset_n, asynchronous, active-low; clock i_clk.
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_pc  in  16  fetch byte address from CPU
- o_instruction  out  32  instruction word at i_pc
- i_address  in  16  data word index from CPU
- i_rw  in  1  0 = read, 1 = write
- i_data  in  32  write data from CPU
- o_data  out  32  read data to CPU
- i_load_valid  in  1  loader byte valid
- o_load_ready  out  1  loader can accept a byte
- i_load_byte  in  8  program byte, little-endian within each word
- i_load_last  in  1  final byte of the program, qualified by i_load_valid
- o_cpu_reset_n  out  1  active-low reset to the CPU
- o_mmio_data  out  32  MMIO output register (only with the macro)
- o_mmio_strobe  out  1  one-cycle pulse when the MMIO register is written (only with the macro)

## Operation
- FSM states are LOAD, DONE and RUN. Reset enters LOAD.
  - LOAD: o_load_ready=1. Each handshake (valid && ready at a rising edge) shifts one byte into the assembler.
  - The 4th byte of a word writes {b3,b2,b1,b0} to IMEM[word_ptr] on the same edge, then word_ptr increments.
  - i_load_last with a partial word writes that word with zeros in the missing upper bytes, then goes to DONE.
  - A full 4th-byte write at word_ptr = IMEM_WORDS-1 goes to DONE even if i_load_last is not asserted.
  - DONE: o_load_ready=0, one cycle, then RUN.
  - RUN: o_load_ready=0, o_cpu_reset_n=1. The FSM stays in RUN until reset.
- Instruction read: o_instruction = IMEM[i_pc[15:2]] when the index is below IMEM_WORDS, otherwise 0 (NOP). i_pc[1:0] is ignored.
- Data read: o_data = DMEM[i_address] when i_address < DMEM_WORDS, otherwise 0. Reads are combinational in every state.
- Data write: when i_rw=1 and state is RUN, DMEM[i_address] <= i_data at the rising edge. Writes with i_address >= DMEM_WORDS are dropped.
- In LOAD and DONE, i_rw is ignored because the CPU is in reset and its bus outputs may be X.
- Memories are not cleared by reset. IMEM words beyond the last loaded word keep their prior contents.

## Timing
- Reset values: o_cpu_reset_n=0, o_load_ready=1, word_ptr=0, byte count=0, o_mmio_data=0, o_mmio_strobe=0.
- Read latency is 0 cycles (combinational), because the CPU samples o_instruction and o_data at the next edge.
- Read-during-write to the same DMEM word returns the old data that cycle and the new data from the next cycle.
- Load completion: if the last byte is accepted at edge N, the IMEM write happens at edge N, DONE holds for cycle N to N+1, and o_cpu_reset_n rises (registered) after edge N+1.
- Handshake: bytes presented while o_load_ready=0 are dropped. i_load_valid may stay high across cycles, giving one byte per cycle.
- Reset asserted mid-load: the FSM returns to LOAD, word_ptr=0, the partial word is discarded, and o_cpu_reset_n goes low immediately (asynchronously).

## Configuration
- BUS_MEMORY_MMIO_EN defined:
  - A data write in RUN to i_address = 16'hFFFF loads o_mmio_data and pulses o_mmio_strobe high for the next cycle.
  - A data read of 16'hFFFF returns o_mmio_data.
  - 16'hFFFF never aliases DMEM.
- BUS_MEMORY_MMIO_EN undefined: o_mmio_data and o_mmio_strobe are tied to 0, and 16'hFFFF behaves as an out-of-range address.

## Structure
- Shared package: RW_READ/RW_WRITE, MMIO_ADDR = 16'hFFFF, the loader FSM state enum, and the NOP encoding (0). These constants are shared with the CPU.
- One natural sub-module, bus_memory_loader: the FSM, byte assembler and word_ptr. It outputs the IMEM write enable, address and data, plus o_cpu_reset_n. The memory arrays stay in the top module.

## Test plan
- Load bytes 01 00 00 00, 03 21 00 00 with last on the 8th byte. Expect IMEM[0]=32'h00000001 and IMEM[1]=32'h00002103, and o_cpu_reset_n high 2 edges after the last byte.
- Load 5 bytes AA BB CC DD EE with last on EE. Expect IMEM[1]=32'h000000EE and ready low thereafter; a 6th byte is not accepted.
- In RUN:
  - write DMEM[5]=32'hDEADBEEF; expect o_data on the same cycle is the old value and 32'hDEADBEEF the next cycle;
  - read address 300; expect 0;
  - write to 300; expect no DMEM word changed.
- During LOAD, drive i_rw=1, i_address=3, i_data=32'h1234 for 4 cycles. Expect DMEM[3] unchanged after release.
- Drop i_reset_n after 6 loaded bytes, then reload 4 bytes 11 22 33 44. Expect IMEM[0]=32'h44332211 and the CPU held in reset throughout.
- With BUS_MEMORY_MMIO_EN, write 32'h0000CAFE to 16'hFFFF. Expect o_mmio_data=32'h0000CAFE, o_mmio_strobe high for exactly one cycle, and a readback of 32'h0000CAFE.

Source files
------------

// File: rtl/bus_memory_pkg.sv
// bus_memory_pkg: bus constants and loader state encoding shared between bus_memory and the CPU.
package bus_memory_pkg;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam logic [15:0] MMIO_ADDR = 16'hFFFF;
  localparam logic [31:0] NOP = 32'h0;
  typedef enum logic [1:0] {LOAD, DONE, RUN} load_state_t;
endpackage

// File: rtl/bus_memory_loader.sv
// bus_memory_loader: boot FSM that assembles little-endian loader bytes into IMEM words
// and holds the CPU in reset until the program is in place.
module bus_memory_loader
  import bus_memory_pkg::*;
#(
  parameter int IMEM_WORDS = 256
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_load_valid,
  input  logic [7:0]                    i_load_byte,
  input  logic                          i_load_last,
  output logic                          o_load_ready,
  output logic                          o_imem_we,
  output logic [$clog2(IMEM_WORDS)-1:0] o_imem_addr,
  output logic [31:0]                   o_imem_wdata,
  output logic                          o_cpu_reset_n
);
  localparam int AW = $clog2(IMEM_WORDS);
  load_state_t r_state, w_next;
  logic [AW-1:0] r_ptr;
  logic [1:0] r_count;
  logic [23:0] r_bytes;
  logic r_cpu_reset_n;
  logic w_hs, w_we;
  logic [31:0] w_word;
  assign o_load_ready = r_state == LOAD;
  assign w_hs = i_load_valid && o_load_ready;
  assign w_we = w_hs && (r_count == 2'd3 || i_load_last);
  // unfilled bytes of r_bytes are always zero, so a short last word comes out zero-padded
  assign w_word = {8'h0, r_bytes} | ({24'h0, i_load_byte} << {r_count, 3'b0});
  always_comb begin
    w_next = r_state;
    w_next = r_state == LOAD ? ((w_we && (i_load_last || r_ptr == AW'(IMEM_WORDS - 1))) ? DONE : LOAD) : RUN;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= LOAD;
      r_ptr <= '0;
      r_count <= '0;
      r_bytes <= '0;
      r_cpu_reset_n <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cpu_reset_n <= w_next == RUN;
      if (w_hs) begin
        r_count <= w_we ? 2'd0 : r_count + 2'd1;
        r_bytes <= w_we ? 24'h0 : w_word[23:0];
        if (w_we) r_ptr <= r_ptr + 1'b1;
      end
    end
  end
  assign o_imem_we = w_we;
  assign o_imem_addr = r_ptr;
  assign o_imem_wdata = w_word;
  assign o_cpu_reset_n = r_cpu_reset_n;
endmodule

// File: rtl/bus_memory.sv
// bus_memory: IMEM/DMEM responder for the CPU with a byte-stream boot loader.
// Define BUS_MEMORY_MMIO_EN to add the MMIO output register at address 16'hFFFF.
module bus_memory
  import bus_memory_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_pc,
  output logic [31:0] o_instruction,
  input  logic [15:0] i_address,
  input  logic        i_rw,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  input  logic        i_load_valid,
  output logic        o_load_ready,
  input  logic [7:0]  i_load_byte,
  input  logic        i_load_last,
  output logic        o_cpu_reset_n,
  output logic [31:0] o_mmio_data,
  output logic        o_mmio_strobe
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  logic [31:0] r_imem [IMEM_WORDS];
  logic [31:0] r_dmem [DMEM_WORDS];
  logic w_imem_we, w_d_hit, w_dmem_we;
  logic [IAW-1:0] w_imem_addr;
  logic [31:0] w_imem_wdata, w_dmem_rd;
  bus_memory_loader #(.IMEM_WORDS(IMEM_WORDS)) u_loader (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_load_valid(i_load_valid),
    .i_load_byte(i_load_byte),
    .i_load_last(i_load_last),
    .o_load_ready(o_load_ready),
    .o_imem_we(w_imem_we),
    .o_imem_addr(w_imem_addr),
    .o_imem_wdata(w_imem_wdata),
    .o_cpu_reset_n(o_cpu_reset_n)
  );
  always_ff @(posedge i_clk) begin
    if (w_imem_we) r_imem[w_imem_addr] <= w_imem_wdata;
  end
  assign o_instruction = 32'(i_pc[15:2]) < IMEM_WORDS ? r_imem[i_pc[IAW+1:2]] : NOP;
  // the MMIO address is carved out of DMEM even in a build without the register
  assign w_d_hit = i_address != MMIO_ADDR && 32'(i_address) < DMEM_WORDS;
  assign w_dmem_rd = w_d_hit ? r_dmem[i_address[DAW-1:0]] : 32'h0;
  assign w_dmem_we = o_cpu_reset_n && i_rw == RW_WRITE && w_d_hit;
  always_ff @(posedge i_clk) begin
    if (w_dmem_we) r_dmem[i_address[DAW-1:0]] <= i_data;
  end
`ifdef BUS_MEMORY_MMIO_EN
  logic [31:0] r_mmio_data;
  logic r_mmio_strobe;
  logic w_mmio_we;
  assign w_mmio_we = o_cpu_reset_n && i_rw == RW_WRITE && i_address == MMIO_ADDR;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mmio_data <= '0;
      r_mmio_strobe <= 1'b0;
    end else begin
      r_mmio_strobe <= w_mmio_we;
      if (w_mmio_we) r_mmio_data <= i_data;
    end
  end
  assign o_data = i_address == MMIO_ADDR ? r_mmio_data : w_dmem_rd;
  assign o_mmio_data = r_mmio_data;
  assign o_mmio_strobe = r_mmio_strobe;
`else
  assign o_data = w_dmem_rd;
  assign o_mmio_data = 32'h0;
  assign o_mmio_strobe = 1'b0;
`endif
endmodule
